// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width and the return-stack state encoding.
package cpu_pkg;

  localparam int PC_W = 10;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;

endpackage

// File: rtl/ret_stack_if.sv
// Push/pop subroutine interface between the control unit (master) and the return stack (slave).
interface ret_stack_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 16
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_in;
  logic             clr_err;
  logic [WIDTH-1:0] d_out;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             locked;

  modport master (
    output push, pop, d_in, clr_err,
    input  d_out, count, empty, full, overflow, underflow, locked
  );

  modport slave (
    input  push, pop, d_in, clr_err,
    output d_out, count, empty, full, overflow, underflow, locked
  );

endinterface

// File: rtl/ret_stack.sv
// Hardware return-address stack with occupancy tracking, sticky error flags
// and a lock state that freezes the stack until clr_err.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  ret_stack_if.slave  bus
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);

  state_e           state_q, state_d;
  logic [PTR_W:0]   sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W:0]   sp_m1;
  logic [PTR_W-1:0] top_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);
  assign sp_m1    = sp_q - SP_ONE;
  assign top_idx  = sp_m1[PTR_W-1:0];

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = sp_q[PTR_W-1:0];

    case (state_q)
      ST_RUN: begin
        if (bus.clr_err) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
        // An error raised this cycle overrides a simultaneous clr_err.
        if (bus.push && bus.pop) begin
          if (is_empty) begin
            underflow_d = 1'b1;
            state_d     = ST_ERR;
          end else begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
          end
        end else if (bus.push) begin
          if (is_full) begin
            overflow_d = 1'b1;
            state_d    = ST_ERR;
          end else begin
            wr_en = 1'b1;
            sp_d  = sp_q + SP_ONE;
          end
        end else if (bus.pop) begin
          if (is_empty) begin
            underflow_d = 1'b1;
            state_d     = ST_ERR;
          end else begin
            sp_d = sp_m1;
          end
        end
      end
      ST_ERR: begin
        if (bus.clr_err) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; d_out masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.d_in;
    end
  end

  assign bus.d_out     = is_empty ? '0 : mem_q[top_idx];
  assign bus.count     = sp_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.locked    = (state_q == ST_ERR);

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ret_stack;

  localparam int WIDTH = 10;
  localparam int DEPTH = 16;

  typedef struct {
    string      name;
    logic       push;
    logic       pop;
    logic [9:0] d_in;
    logic       clr;
    int         exp_count;
    logic [9:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;
    logic       exp_lock;
  } vec_t;

  logic clk;
  logic reset;
  int   total_checks;
  int   passed_checks;
  vec_t vecs[$];

  logic [9:0] model_q[$];
  logic       model_ovf;
  logic       model_unf;
  logic       model_lock;

  ret_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int exp_count,
                              input logic [9:0] exp_dout, input logic exp_ovf,
                              input logic exp_unf, input logic exp_lock);
    logic exp_empty;
    logic exp_full;
    exp_empty = (exp_count == 0);
    exp_full  = (exp_count == DEPTH);
    total_checks++;
    if (int'(bus.count) == exp_count && bus.d_out == exp_dout &&
        bus.empty == exp_empty && bus.full == exp_full &&
        bus.overflow == exp_ovf && bus.underflow == exp_unf &&
        bus.locked == exp_lock) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got count=%0d d_out=%h empty=%b full=%b ovf=%b unf=%b lock=%b, want count=%0d d_out=%h empty=%b full=%b ovf=%b unf=%b lock=%b",
               name, bus.count, bus.d_out, bus.empty, bus.full, bus.overflow,
               bus.underflow, bus.locked, exp_count, exp_dout, exp_empty,
               exp_full, exp_ovf, exp_unf, exp_lock);
    end
  endtask

  task automatic apply_stimulus(input logic p, input logic o,
                                input logic [9:0] d, input logic c);
    bus.push    = p;
    bus.pop     = o;
    bus.d_in    = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic p, input logic o,
                         input logic [9:0] d, input logic c, input int ec,
                         input logic [9:0] ed, input logic eo, input logic eu,
                         input logic el);
    vec_t v;
    v.name = n; v.push = p; v.pop = o; v.d_in = d; v.clr = c;
    v.exp_count = ec; v.exp_dout = ed; v.exp_ovf = eo; v.exp_unf = eu;
    v.exp_lock = el;
    vecs.push_back(v);
  endtask

  // Reference model: a bounded LIFO queue plus flags, stepped by the stack's rules.
  task automatic model_step(input logic p, input logic o, input logic [9:0] d,
                            input logic c);
    if (model_lock) begin
      if (c) begin
        model_ovf  = 1'b0;
        model_unf  = 1'b0;
        model_lock = 1'b0;
      end
    end else begin
      if (c) begin
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end
      if (p && o) begin
        if (model_q.size() == 0) begin
          model_unf = 1'b1; model_lock = 1'b1;
        end else begin
          model_q[model_q.size()-1] = d;
        end
      end else if (p) begin
        if (model_q.size() == DEPTH) begin
          model_ovf = 1'b1; model_lock = 1'b1;
        end else begin
          model_q.push_back(d);
        end
      end else if (o) begin
        if (model_q.size() == 0) begin
          model_unf = 1'b1; model_lock = 1'b1;
        end else begin
          void'(model_q.pop_back());
        end
      end
    end
  endtask

  initial begin
    logic [9:0] last_val;
    logic [9:0] exp_top;
    logic       p, o, c, push_heavy;
    logic [9:0] d;

    total_checks  = 0;
    passed_checks = 0;
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.d_in    = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset_state", 0, 10'h000, 1'b0, 1'b0, 1'b0);

    add_vec("idle",          0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add_vec("push_005",      1, 0, 10'h005, 0, 1, 10'h005, 0, 0, 0);
    add_vec("push_00A",      1, 0, 10'h00A, 0, 2, 10'h00A, 0, 0, 0);
    add_vec("push_3FF",      1, 0, 10'h3FF, 0, 3, 10'h3FF, 0, 0, 0);
    add_vec("pop_to_00A",    0, 1, 10'h000, 0, 2, 10'h00A, 0, 0, 0);
    add_vec("pop_to_005",    0, 1, 10'h000, 0, 1, 10'h005, 0, 0, 0);
    add_vec("pop_to_empty",  0, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add_vec("push_0AA",      1, 0, 10'h0AA, 0, 1, 10'h0AA, 0, 0, 0);
    add_vec("push_005b",     1, 0, 10'h005, 0, 2, 10'h005, 0, 0, 0);
    add_vec("replace_top",   1, 1, 10'h123, 0, 2, 10'h123, 0, 0, 0);
    add_vec("pop_after_rep", 0, 1, 10'h000, 0, 1, 10'h0AA, 0, 0, 0);
    add_vec("pop_empty_ok",  0, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add_vec("pop_underflow", 0, 1, 10'h000, 0, 0, 10'h000, 0, 1, 1);
    add_vec("push_in_err",   1, 0, 10'h050, 0, 0, 10'h000, 0, 1, 1);
    add_vec("clr_err",       0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0);
    add_vec("push_050",      1, 0, 10'h050, 0, 1, 10'h050, 0, 0, 0);
    add_vec("pop_050",       0, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);
    add_vec("pushpop_empty", 1, 1, 10'h099, 0, 0, 10'h000, 0, 1, 1);
    add_vec("clr_err2",      0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0);
    add_vec("clr_with_push", 1, 0, 10'h077, 1, 1, 10'h077, 0, 0, 0);
    add_vec("pop_077",       0, 1, 10'h000, 0, 0, 10'h000, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].push, vecs[i].pop, vecs[i].d_in, vecs[i].clr);
      check_output(vecs[i].name, vecs[i].exp_count, vecs[i].exp_dout,
                   vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_lock);
    end

    // Fill to DEPTH, then exercise overflow, lock, and clear.
    last_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last_val = 10'((i * 37 + 5) & 10'h3FF);
      apply_stimulus(1'b1, 1'b0, last_val, 1'b0);
    end
    check_output("fill_full", DEPTH, last_val, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 10'h111, 1'b0);
    check_output("overflow", DEPTH, last_val, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 10'h000, 1'b0);
    check_output("pop_in_err", DEPTH, last_val, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 10'h000, 1'b1);
    check_output("clr_after_ovf", DEPTH, last_val, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 10'h111, 1'b1);
    check_output("ovf_beats_clr", DEPTH, last_val, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle while full and locked.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("async_reset", 0, 10'h000, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 10'h000, 1'b0);
    check_output("after_reset", 0, 10'h000, 1'b0, 1'b0, 1'b0);

    model_q.delete();
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
    model_lock = 1'b0;
    for (int i = 0; i < 600; i++) begin
      push_heavy = ((i / 60) % 2) == 0;
      p = push_heavy ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 25);
      o = push_heavy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 70);
      c = ($urandom_range(0, 15) == 0);
      d = 10'($urandom);
      model_step(p, o, d, c);
      apply_stimulus(p, o, d, c);
      exp_top = (model_q.size() == 0) ? 10'h000 : model_q[model_q.size()-1];
      check_output($sformatf("rand_%0d", i), model_q.size(), exp_top,
                   model_ovf, model_unf, model_lock);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
